sram_arb_nx1: RTL

SRAM_ARB_NX1 -- requirements
Module: sram_arb_nx1

---
 rtl/sram_arb_nx1.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/sram_arb_nx1.sv
// sram_arb_nx1 -- N-to-1 arbiter for SRAM-like request/response buses.
//
// Several SRAM-like masters share one downstream SRAM-like port. Address
// requests are granted round-robin; once a master has been offered to the
// downstream port it stays granted until its address handshake completes.
// The index of every accepted request is remembered in a small in-order id
// FIFO so that responses (which the downstream returns in order) are steered
// back to the master that issued them with no added latency.
//
// Parameters
//   N_MASTER    number of masters (2..8)
//   DATA_W      address / data width
//   OUTSTANDING max transactions in flight (power of 2, 2..16)
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   m_req, m_wr               per-master request / write flag
//   m_size                    per-master 2-bit transfer size (packed)
//   m_addr, m_wdata           per-master address / write data (packed)
//   m_addr_ok, m_data_ok      per-master address / data handshakes
//   m_rdata                   read data, shared by all masters
//   s_req, s_wr, s_size,
//   s_addr, s_wdata           downstream request
//   s_rdata, s_addr_ok,
//   s_data_ok                 downstream response
//   err_spurious              sticky: s_data_ok seen with nothing in flight

module sram_arb_nx1 #(
  parameter int N_MASTER    = 2,
  parameter int DATA_W      = 32,
  parameter int OUTSTANDING = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_MASTER-1:0]          m_req,
  input  logic [N_MASTER-1:0]          m_wr,
  input  logic [2*N_MASTER-1:0]        m_size,
  input  logic [N_MASTER*DATA_W-1:0]   m_addr,
  input  logic [N_MASTER*DATA_W-1:0]   m_wdata,
  output logic [N_MASTER-1:0]          m_addr_ok,
  output logic [N_MASTER-1:0]          m_data_ok,
  output logic [DATA_W-1:0]            m_rdata,
  output logic                         s_req,
  output logic                         s_wr,
  output logic [1:0]                   s_size,
  output logic [DATA_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  input  logic [DATA_W-1:0]            s_rdata,
  input  logic                         s_addr_ok,
  input  logic                         s_data_ok,
  output logic                         err_spurious
);

  localparam int IDW = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
  localparam int PW  = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW  = PW + 1;

  typedef enum logic {ST_IDLE, ST_LOCK} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [IDW-1:0]      r_rr_ptr;      // master with highest priority
  logic [IDW-1:0]      r_lock_id;
  logic [IDW-1:0]      w_win_id;
  logic                w_win_vld;
  logic [IDW:0]        w_sum;
  logic [2*N_MASTER-1:0] w_req_dbl;
  logic [IDW-1:0]      w_grant_id;
  logic                w_grant_vld;

  logic [IDW-1:0]      r_fifo_mem [OUTSTANDING];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic [IDW-1:0]      w_head_id;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic                w_push;
  logic                w_pop;

  logic [DATA_W-1:0]   w_addr_arr  [N_MASTER];
  logic [DATA_W-1:0]   w_wdata_arr [N_MASTER];
  logic [1:0]          w_size_arr  [N_MASTER];

  // Round-robin search: rotate the request vector so that bit 0 is the
  // current priority holder, take the lowest set bit, then rotate the
  // offset back into a master index (modulo N_MASTER, which need not be a
  // power of 2). Iterating downwards lets the lowest offset win.
  always_comb begin
    w_req_dbl = {m_req, m_req} >> r_rr_ptr;
    w_win_vld = 1'b0;
    w_sum     = '0;
    for (int k = N_MASTER - 1; k >= 0; k--) begin
      if (w_req_dbl[k]) begin
        w_win_vld = 1'b1;
        w_sum     = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      end
    end
    if (w_sum >= (IDW+1)'(N_MASTER)) begin
      w_sum = w_sum - (IDW+1)'(N_MASTER);
    end
    w_win_id = w_sum[IDW-1:0];
  end

  // While locked the grant ignores every other master. If the locked master
  // withdraws its request the grant goes invalid and the FSM drops back.
  always_comb begin
    w_grant_id  = w_win_id;
    w_grant_vld = w_win_vld;
    if (r_state == ST_LOCK) begin
      w_grant_id  = r_lock_id;
      w_grant_vld = m_req[r_lock_id];
    end
  end

  assign w_fifo_full  = (r_count == CW'(OUTSTANDING));
  assign w_fifo_empty = (r_count == '0);
  assign w_head_id    = r_fifo_mem[r_rd_ptr];

  // A full FIFO blocks the request even if a pop frees a slot this cycle;
  // this keeps s_req independent of s_data_ok.
  assign s_req  = ~rst & w_grant_vld & ~w_fifo_full;
  assign w_push = s_req & s_addr_ok;
  assign w_pop  = ~rst & s_data_ok & ~w_fifo_empty;

  generate
    for (genvar gi = 0; gi < N_MASTER; gi++) begin : g_master
      assign w_addr_arr[gi]  = m_addr[gi*DATA_W +: DATA_W];
      assign w_wdata_arr[gi] = m_wdata[gi*DATA_W +: DATA_W];
      assign w_size_arr[gi]  = m_size[gi*2 +: 2];
      assign m_addr_ok[gi]   = w_push & (w_grant_id == IDW'(gi));
      assign m_data_ok[gi]   = w_pop & (w_head_id == IDW'(gi));
    end
  endgenerate

  assign s_wr    = m_wr[w_grant_id];
  assign s_size  = w_size_arr[w_grant_id];
  assign s_addr  = w_addr_arr[w_grant_id];
  assign s_wdata = w_wdata_arr[w_grant_id];
  assign m_rdata = s_rdata;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_win_vld && !w_push) w_state_next = ST_LOCK;
      ST_LOCK: if (!m_req[r_lock_id] || w_push) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_lock_id    <= '0;
      r_rr_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      err_spurious <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_IDLE) begin
        r_lock_id <= w_win_id;
      end
      if (w_push) begin
        r_rr_ptr <= (w_grant_id == IDW'(N_MASTER - 1)) ? '0 : w_grant_id + 1'b1;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (s_data_ok && w_fifo_empty) begin
        err_spurious <= 1'b1;
      end
    end
  end

  // Id storage needs no reset: only entries between the pointers are read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= w_grant_id;
    end
  end

endmodule
